// File: rtl/axi_sram_slave_if.sv
// AXI bus bundle shared by the L2 cache bus master and SRAM-style slaves.
// No rlast/bresp: the master counts beats itself.
interface axi_interface #(
    parameter int AXI_DATA_WIDTH = 32
);
    logic [31:0]               awaddr;
    logic [7:0]                awlen;
    logic                      awvalid;
    logic                      awready;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;
    logic                      bvalid;
    logic                      bready;
    logic [31:0]               araddr;
    logic [7:0]                arlen;
    logic                      arvalid;
    logic                      arready;
    logic                      rvalid;
    logic                      rready;
    logic [AXI_DATA_WIDTH-1:0] rdata;

    modport master (
        output awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
               araddr, arlen, arvalid, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );

    modport slave (
        input  awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
               araddr, arlen, arvalid, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI slave over a single-ported word RAM; one incrementing burst at a time,
// writes take priority over reads.
module axi_sram_slave #(
    parameter int MEM_WORDS = 4096,
    parameter int ADDR_BITS = $clog2(MEM_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    axi_interface.slave axi_bus
);

    typedef enum logic [1:0] {IDLE, WRITE, WRITE_RESP, READ} state_t;

    state_t                state, state_next;
    logic [7:0]            count;
    logic [ADDR_BITS-1:0]  index;
    logic [31:0]           rdata;
    logic [31:0]           mem [MEM_WORDS];

    logic [ADDR_BITS-1:0]  aw_index, ar_index;
    logic                  aw_take, ar_take, w_beat, r_beat;
    logic                  unused_bits;

    assign aw_index = axi_bus.awaddr[ADDR_BITS+1:2];
    assign ar_index = axi_bus.araddr[ADDR_BITS+1:2];

    // wlast and out-of-range address bits are deliberately ignored
    assign unused_bits = ^{axi_bus.wlast,
                           axi_bus.awaddr[31:ADDR_BITS+2], axi_bus.awaddr[1:0],
                           axi_bus.araddr[31:ADDR_BITS+2], axi_bus.araddr[1:0]};

    assign aw_take = (state == IDLE) && axi_bus.awvalid;
    assign ar_take = (state == IDLE) && !axi_bus.awvalid && axi_bus.arvalid;
    assign w_beat  = (state == WRITE) && axi_bus.wvalid;
    assign r_beat  = (state == READ) && axi_bus.rready;

    assign axi_bus.awready = (state == IDLE);
    assign axi_bus.arready = (state == IDLE) && !axi_bus.awvalid;
    assign axi_bus.wready  = (state == WRITE);
    assign axi_bus.bvalid  = (state == WRITE_RESP);
    assign axi_bus.rvalid  = (state == READ);
    assign axi_bus.rdata   = rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (axi_bus.awvalid)      state_next = WRITE;
                else if (axi_bus.arvalid) state_next = READ;
            end
            WRITE:      if (axi_bus.wvalid && count == 8'd0) state_next = WRITE_RESP;
            WRITE_RESP: if (axi_bus.bready) state_next = IDLE;
            READ:       if (axi_bus.rready && count == 8'd0) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Read path prefetches: rdata always holds the beat currently offered,
    // and index points at the next word to fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            index <= '0;
            rdata <= '0;
        end else if (aw_take) begin
            count <= axi_bus.awlen;
            index <= aw_index;
        end else if (ar_take) begin
            count <= axi_bus.arlen;
            index <= ar_index + 1'b1;
            rdata <= mem[ar_index];
        end else if (w_beat) begin
            index <= index + 1'b1;
            if (count != 8'd0) count <= count - 8'd1;
        end else if (r_beat && count != 8'd0) begin
            count <= count - 8'd1;
            index <= index + 1'b1;
            rdata <= mem[index];
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat) mem[index] <= axi_bus.wdata;
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised scoreboard bench for axi_sram_slave against a flat word-array model.
module tb_axi_sram_slave;
    localparam int WORDS = 16;
    typedef logic [31:0] word_q_t[$];

    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    axi_interface bus ();

    axi_sram_slave #(.MEM_WORDS(WORDS)) dut (
        .clk(clk),
        .reset(rst_n),
        .axi_bus(bus)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] model [WORDS];
    logic [31:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic int widx(input logic [31:0] addr, input int beat);
        return ((addr / 4) + beat) % WORDS;
    endfunction

    // Monitor: every accepted read beat is popped from the scoreboard
    logic [31:0] held;
    bit stalled = 0;
    always @(negedge clk) begin
        if (!rst_n) stalled = 0;
        else if (bus.rvalid) begin
            if (stalled) check("rdata_stable", bus.rdata, held);
            if (bus.rready) begin
                if (sb.size() == 0) fail("extra_rbeat");
                else check("rdata", bus.rdata, sb.pop_front());
                stalled = 0;
            end else begin
                stalled = 1;
                held = bus.rdata;
            end
        end else stalled = 0;
    end

    task automatic aw_phase(input logic [31:0] addr, input int len);
        bit hs;
        int t = 0;
        bus.awaddr = addr; bus.awlen = len[7:0]; bus.awvalid = 1;
        do begin
            @(negedge clk); hs = bus.awready;
            @(posedge clk); #1; t++;
        end while (!hs && t < 100);
        if (!hs) fail("aw_timeout");
        bus.awvalid = 0;
    endtask

    task automatic w_phase(input logic [31:0] addr, input int len, input word_q_t data, input bit gaps);
        for (int i = 0; i <= len; i++) begin
            bit acc;
            int t = 0;
            do begin
                bus.wvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.wdata  = bus.wvalid ? data[i] : $urandom;
                bus.wlast  = (i == len);
                @(negedge clk); acc = bus.wvalid && bus.wready;
                @(posedge clk); #1; t++;
            end while (!acc && t < 100);
            if (!acc) begin fail("w_timeout"); return; end
            model[widx(addr, i)] = data[i];
        end
        bus.wvalid = 0; bus.wlast = 0;
        @(negedge clk); check("bvalid_after_last", bus.bvalid, 1);
        @(posedge clk); #1;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk); check("bvalid_hold", bus.bvalid, 1);
            @(posedge clk); #1;
        end
        bus.bready = 1;
        @(negedge clk); check("bvalid_hs", bus.bvalid, 1);
        @(posedge clk); #1;
        bus.bready = 0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len, input word_q_t data, input bit gaps);
        aw_phase(addr, len);
        w_phase(addr, len, data, gaps);
    endtask

    // mode 0: rready always 1 (checks back-to-back rvalid), 1: random, 2: fixed stall pattern
    task automatic read_burst(input logic [31:0] addr, input int len, input int mode, input bit first_ready);
        bit hs;
        int t = 0;
        bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        bus.araddr = addr; bus.arlen = len[7:0]; bus.arvalid = 1;
        do begin
            @(negedge clk); hs = bus.arready;
            if (first_ready && t == 0) check("arready_after_b", bus.arready, 1);
            if (hs) for (int i = 0; i <= len; i++) sb.push_back(model[widx(addr, i)]);
            @(posedge clk); #1; t++;
        end while (!hs && t < 100);
        bus.arvalid = 0;
        if (!hs) begin fail("ar_timeout"); return; end
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            case (mode)
                0: bus.rready = 1;
                1: bus.rready = $urandom_range(0, 1);
                default: bus.rready = (t < 7) ? pat[t] : 1'b1;
            endcase
            @(negedge clk);
            if (mode == 0) check("rvalid_continuous", bus.rvalid, 1);
            @(posedge clk); #1; t++;
        end
        if (sb.size() != 0) fail("r_timeout");
        bus.rready = 0;
        @(negedge clk); check("rvalid_after_burst", bus.rvalid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        word_q_t d;
        bus.awaddr = 0; bus.awlen = 0; bus.awvalid = 0;
        bus.wdata = 0; bus.wlast = 0; bus.wvalid = 0; bus.bready = 0;
        bus.araddr = 0; bus.arlen = 0; bus.arvalid = 0; bus.rready = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", bus.awready, 1);
        check("rst_arready", bus.arready, 1);
        check("rst_wready", bus.wready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rdata", bus.rdata, 0);
        @(posedge clk); #1; rst_n = 1;

        // single write then read
        d = '{32'hDEADBEEF};
        write_burst(32'h10, 0, d, 0);
        read_burst(32'h10, 0, 0, 0);

        // full 16-beat burst (covers every word), read back without stalls
        d = {};
        for (int i = 0; i < 16; i++) d.push_back(i * 32'h01010101);
        write_burst(32'h40, 15, d, 0);
        read_burst(32'h40, 15, 0, 0);

        // read backpressure and write gaps
        read_burst(32'h44, 3, 2, 0);
        d = {};
        for (int i = 0; i < 6; i++) d.push_back($urandom);
        write_burst(32'h20, 5, d, 1);
        read_burst(32'h20, 5, 1, 0);

        // simultaneous AW and AR: write first, then read of the same words
        d = '{32'hA5A5_0001, 32'hA5A5_0002};
        bus.araddr = 32'h8; bus.arlen = 1; bus.arvalid = 1;
        bus.awaddr = 32'h8; bus.awlen = 1; bus.awvalid = 1;
        @(negedge clk);
        check("both_awready", bus.awready, 1);
        check("both_arready", bus.arready, 0);
        @(posedge clk); #1; bus.awvalid = 0;
        w_phase(32'h8, 1, d, 0);
        read_burst(32'h8, 1, 0, 1);

        // wrap across the top of the RAM
        d = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
        write_burst(32'h38, 3, d, 0);
        read_burst(32'h00, 1, 0, 0);
        read_burst(32'h38, 3, 1, 0);

        // reset in the middle of an 8-beat read
        bus.araddr = 32'h0; bus.arlen = 7; bus.arvalid = 1;
        @(negedge clk);
        if (bus.arready) for (int i = 0; i < 8; i++) sb.push_back(model[i]);
        else fail("rst_ar_hs");
        @(posedge clk); #1; bus.arvalid = 0; bus.rready = 1;
        @(posedge clk); #1; bus.rready = 0;
        #2 rst_n = 0;
        #1;
        check("mid_rst_rvalid", bus.rvalid, 0);
        check("mid_rst_rdata", bus.rdata, 0);
        check("mid_rst_wready", bus.wready, 0);
        check("mid_rst_bvalid", bus.bvalid, 0);
        sb.delete();
        @(posedge clk); @(posedge clk); #1; rst_n = 1;
        @(negedge clk); check("post_rst_arready", bus.arready, 1);
        @(posedge clk); #1;
        read_burst(32'h4, 7, 1, 0);

        // random traffic, upper address bits exercise aliasing
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a = $urandom;
            int l = $urandom_range(0, 20);
            if ($urandom_range(0, 1) != 0) begin
                d = {};
                for (int i = 0; i <= l; i++) d.push_back($urandom);
                write_burst(a, l, d, $urandom_range(0, 1));
            end else read_burst(a, l, $urandom_range(0, 2), 0);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
